// File: rtl/msp430_pkg.sv
// rtl/msp430_pkg.sv - Shared types and constants for the fetch path
//
// Contents:
//   DEFAULT_SIZE  default data/address width
//   WORD_STEP     byte increment between sequential instruction words
//   fq_state_t    fetch queue states (FQ_RUN, FQ_DRAIN)
package msp430_pkg;

  localparam int DEFAULT_SIZE = 16;
  localparam int WORD_STEP    = 2;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_t;

endpackage

// File: rtl/fq_ram.sv
// rtl/fq_ram.sv - Fetch queue storage, one write port and one async read port
//
// Ports:
//   clk      in   clock; write on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   word written at wr_addr
//   rd_addr  in   read index
//   rd_data  out  combinational read of rd_addr
module fq_ram
  import msp430_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_SIZE,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Instruction prefetch queue between memory bus and decoder
//
// Optional feature macro: FQ_BYPASS_EN (returning word shown to the decoder
// in its return cycle when the queue is empty).
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   RST_VEC   in   fetch start address loaded while rst is low
//   flush     in   redirect fetching to flush_PC, discard buffered/in-flight words
//   flush_PC  in   redirect address (bit 0 ignored)
//   halt      in   suppress new fetch requests
//   FQ_req    out  fetch request to the arbiter
//   FQ_MAB    out  fetch address
//   FQ_gnt    in   arbiter grant; FQ_req & FQ_gnt issues a fetch
//   MDB_out   in   read data, valid the cycle after an issue
//   IW_valid  out  head word valid
//   IW_out    out  head instruction word
//   IW_addr   out  head word address
//   IW_ready  in   decoder accepts head word
//   FQ_count  out  number of buffered words
module fetch_queue
  import msp430_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] RST_VEC,
  input  logic            flush,
  input  logic [SIZE-1:0] flush_PC,
  input  logic            halt,
  output logic            FQ_req,
  output logic [SIZE-1:0] FQ_MAB,
  input  logic            FQ_gnt,
  input  logic [SIZE-1:0] MDB_out,
  output logic            IW_valid,
  output logic [SIZE-1:0] IW_out,
  output logic [SIZE-1:0] IW_addr,
  input  logic            IW_ready,
  output logic [CW-1:0]   FQ_count
);

  localparam int AW = $clog2(DEPTH);

  fq_state_t         state, state_next;
  logic [SIZE-1:0]   fa, fa_cur, ret_addr;
  logic              fa_loaded, inflight;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [2*SIZE-1:0] rd_data;
  logic              empty, drop, ret_ok, bypass, head_valid;
  logic              pop, pop_stored, push, req, issue;
  logic [CW:0]       occupancy;

  // Until the first clock after reset the fetch address tracks RST_VEC
  // directly, so no register needs an asynchronous load from an input.
  assign fa_cur = fa_loaded ? fa : RST_VEC;

  assign empty  = (count == '0);
  // A return coinciding with a flush, or arriving while draining, is stale.
  assign drop   = flush | (state == FQ_DRAIN);
  assign ret_ok = inflight & ~drop;

`ifdef FQ_BYPASS_EN
  assign bypass = empty & ret_ok;
`else
  assign bypass = 1'b0;
`endif

  assign head_valid = ~flush & (~empty | bypass);
  assign pop        = head_valid & IW_ready;
  assign pop_stored = pop & ~empty;
  // A bypassed word consumed in its return cycle never enters storage.
  assign push       = ret_ok & ~(bypass & IW_ready);

  // Occupancy once this cycle's return and pop have settled; issuing now
  // adds one more word next cycle, so this must stay below DEPTH.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      FQ_RUN: begin
        req = rst & ~halt & ~flush & (occupancy < (CW+1)'(DEPTH));
        if (flush && inflight) begin
          state_next = FQ_DRAIN;
        end
      end
      FQ_DRAIN: begin
        // Any stale return is dropped this cycle; refetch from the next one.
        state_next = FQ_RUN;
      end
      default: state_next = FQ_RUN;
    endcase
  end

  assign issue = req & FQ_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FQ_RUN;
      fa        <= '0;
      fa_loaded <= 1'b0;
      inflight  <= 1'b0;
      ret_addr  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      fa_loaded <= 1'b1;
      inflight  <= issue;
      if (issue) begin
        ret_addr <= fa_cur;
      end
      if (flush) begin
        fa     <= flush_PC & ~SIZE'(1);
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        fa <= issue ? fa_cur + SIZE'(WORD_STEP) : fa_cur;
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_stored) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop_stored);
      end
    end
  end

  fq_ram #(
    .WIDTH (2 * SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({ret_addr, MDB_out}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // While empty the address output shows the next fetch address, which is
  // RST_VEC during reset.
  always_comb begin
    IW_out  = '0;
    IW_addr = fa_cur;
    if (!empty) begin
      {IW_addr, IW_out} = rd_data;
    end else if (bypass) begin
      IW_addr = ret_addr;
      IW_out  = MDB_out;
    end
  end

  assign FQ_req   = req;
  assign FQ_MAB   = fa_cur;
  assign IW_valid = head_valid;
  assign FQ_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - Self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] RST_VEC = 16'hF800;
  logic            flush = 1'b0;
  logic [SIZE-1:0] flush_PC = '0;
  logic            halt = 1'b0;
  logic            FQ_req;
  logic [SIZE-1:0] FQ_MAB;
  logic            FQ_gnt = 1'b0;
  logic [SIZE-1:0] MDB_out = '0;
  logic            IW_valid;
  logic [SIZE-1:0] IW_out;
  logic [SIZE-1:0] IW_addr;
  logic            IW_ready = 1'b0;
  logic [CW-1:0]   FQ_count;

  fetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .RST_VEC  (RST_VEC),
    .flush    (flush),
    .flush_PC (flush_PC),
    .halt     (halt),
    .FQ_req   (FQ_req),
    .FQ_MAB   (FQ_MAB),
    .FQ_gnt   (FQ_gnt),
    .MDB_out  (MDB_out),
    .IW_valid (IW_valid),
    .IW_out   (IW_out),
    .IW_addr  (IW_addr),
    .IW_ready (IW_ready),
    .FQ_count (FQ_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the queue is a sequence of consecutive word addresses.
  int          model_count;
  bit          prev_issued;
  bit          drain;
  logic [15:0] exp_fetch, exp_pop, last_issue;
  int          cyc, first_valid_cyc, n_issue, n_pop, wrap_hits;
  bit          want_first_pop, want_first_issue;
  logic [15:0] first_pop, first_issue;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  task automatic tick();
    bit          issued, pop, ret, exp_req, exp_valid;
    logic [15:0] iss_addr;
    int          occ;
    @(negedge clk);
    issued   = FQ_req && FQ_gnt;
    iss_addr = FQ_MAB;
    pop      = IW_valid && IW_ready && !flush;
    ret      = prev_issued;
    check("count", FQ_count, model_count);
    occ     = model_count + int'(ret) - int'(pop);
    exp_req = !halt && !flush && !drain && (occ < DEPTH);
    check("req", FQ_req, exp_req);
    if (!flush) begin
      exp_valid = (model_count > 0);
`ifdef FQ_BYPASS_EN
      if (model_count == 0 && ret && !drain) exp_valid = 1'b1;
`endif
      check("valid", IW_valid, exp_valid);
    end
    if (IW_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (issued) begin
      check("fetch_addr", FQ_MAB, exp_fetch);
      if (last_issue == 16'hFFFE) begin
        wrap_hits++;
        check("wrap", FQ_MAB, 16'h0000);
      end
      if (want_first_issue) begin
        first_issue = FQ_MAB;
        want_first_issue = 1'b0;
      end
      last_issue = FQ_MAB;
      exp_fetch  = exp_fetch + 16'd2;
      n_issue++;
    end
    if (pop) begin
      check("iw_addr", IW_addr, exp_pop);
      check("iw_out", IW_out, mem_word(exp_pop));
      if (want_first_pop) begin
        first_pop = IW_addr;
        want_first_pop = 1'b0;
      end
      exp_pop = exp_pop + 16'd2;
      n_pop++;
    end
    if (flush) begin
      check("flush_no_issue", issued, 1'b0);
      drain       = ret;
      model_count = 0;
      exp_fetch   = flush_PC & 16'hFFFE;
      exp_pop     = exp_fetch;
      prev_issued = 1'b0;
      last_issue  = 16'h0001;
    end else begin
      if (ret && !drain) model_count++;
      if (pop) model_count--;
      drain       = 1'b0;
      prev_issued = issued;
    end
    @(posedge clk);
    #1;
    MDB_out = issued ? mem_word(iss_addr) : 16'($urandom);
    cyc++;
  endtask

  // Called at posedge+1; holds reset through one rising edge.
  task automatic do_reset(input logic [15:0] vec);
    rst      = 1'b0;
    RST_VEC  = vec;
    flush    = 1'b0;
    halt     = 1'b0;
    FQ_gnt   = 1'b0;
    IW_ready = 1'b0;
    @(negedge clk);
    check("rst_req", FQ_req, 1'b0);
    check("rst_mab", FQ_MAB, vec);
    check("rst_valid", IW_valid, 1'b0);
    check("rst_iw_out", IW_out, 16'h0000);
    check("rst_iw_addr", IW_addr, vec);
    check("rst_count", FQ_count, 0);
    @(posedge clk);
    #1;
    rst             = 1'b1;
    model_count     = 0;
    prev_issued     = 1'b0;
    drain           = 1'b0;
    exp_fetch       = vec;
    exp_pop         = vec;
    last_issue      = 16'h0001;
    cyc             = 0;
    first_valid_cyc = -1;
    n_issue         = 0;
    n_pop           = 0;
    wrap_hits       = 0;
  endtask

  initial begin
    int exp_first;
    #2;
    do_reset(16'hF800);

    // Fill with decoder stalled: exactly DEPTH fetches, then request drops.
    FQ_gnt = 1'b1;
    repeat (10) tick();
    check("fill_issues", n_issue, 4);
    check("fill_last", last_issue, 16'hF806);
    check("fill_req", FQ_req, 1'b0);
    check("fill_count", FQ_count, 4);

    // Streaming: latency to first valid and one word per cycle.
    do_reset(16'h1000);
    FQ_gnt   = 1'b1;
    IW_ready = 1'b1;
    repeat (22) tick();
`ifdef FQ_BYPASS_EN
    exp_first = 1;
`else
    exp_first = 2;
`endif
    check("first_valid_cyc", first_valid_cyc, exp_first);
    check("throughput", n_pop, 22 - exp_first);

    // Address wrap at the top of memory.
    flush    = 1'b1;
    flush_PC = 16'hFFFA;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    check("wrap_seen", wrap_hits > 0, 1'b1);

    // Flush with a fetch in flight and three words buffered.
    do_reset(16'h2000);
    FQ_gnt = 1'b1;
    for (int i = 0; i < 20 && FQ_count != 3; i++) tick();
    check("pre_flush_count", FQ_count, 3);
    check("pre_flush_inflight", prev_issued, 1'b1);
    flush            = 1'b1;
    flush_PC         = 16'hC001;
    want_first_pop   = 1'b1;
    want_first_issue = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush_count", FQ_count, 0);
    IW_ready = 1'b1;
    repeat (8) tick();
    check("flush_first_fetch", first_issue, 16'hC000);
    check("flush_first_pop", first_pop, 16'hC000);

    // Random traffic with alternating grant.
    do_reset(16'h4000);
    for (int i = 0; i < 2000; i++) begin
      FQ_gnt   = (i % 2) == 0;
      IW_ready = 1'($urandom_range(0, 1));
      halt     = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      flush_PC = 16'($urandom);
      tick();
    end
    flush = 1'b0;
    halt  = 1'b0;
    check("rand_pops", n_pop > 200, 1'b1);

    // Reset with a fetch in flight and two words buffered.
    do_reset(16'hF800);
    FQ_gnt = 1'b1;
    for (int i = 0; i < 20 && FQ_count != 2; i++) tick();
    check("pre_rst_count", FQ_count, 2);
    check("pre_rst_inflight", prev_issued, 1'b1);
    do_reset(16'h3000);
    FQ_gnt   = 1'b0;
    IW_ready = 1'b1;
    repeat (3) tick();
    check("rst_drop_count", FQ_count, 0);
    check("rst_drop_valid", IW_valid, 1'b0);
    want_first_pop = 1'b1;
    FQ_gnt = 1'b1;
    repeat (6) tick();
    check("rst_first_pop", first_pop, 16'h3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
